network_stack_rx: RTL and testbench

- Receive-side counterpart of the network_stack transmitter.
- Consumes an RMII dibit stream (CRS_DV/RXD) and strips the preamble/SFD.
- Parses and filters the Ethernet II, IPv4 and UDP headers, then streams the UDP payload out as DATA_SIZE-bit words.
- At end of frame, checks the Ethernet CRC-32 and reports a per-frame good/bad verdict. Downstream logic discards the frame's words if the verdict is bad.

---
 rtl/network_stack_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_network_stack_rx.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_stack_rx.sv
// RMII receiver: strips preamble/SFD, filters Ethernet II / IPv4 / UDP headers, streams the
// UDP payload as DATA_SIZE-bit words and reports a per-frame CRC-32 verdict.
module network_stack_rx #(
    parameter int unsigned N         = 2,
    parameter int unsigned DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 eth_crsdv,
    input  logic [N-1:0]         eth_rxd,
    input  logic [47:0]          mac,
    input  logic [15:0]          udp_dst_port_in,
    output logic                 axiov,
    output logic [DATA_SIZE-1:0] axiod,
    output logic [47:0]          src_mac_out,
    output logic [31:0]          src_ip_out,
    output logic [15:0]          udp_src_port_out,
    output logic [15:0]          payload_length,
    output logic                 frame_done,
    output logic                 frame_good
);
    localparam int unsigned Bytes      = DATA_SIZE / 8;
    localparam logic [31:0] CrcPoly    = 32'hEDB88320;
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        StWaitIdle, StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StPayload, StTrailer, StDrop
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           pre_cnt_q, pre_cnt_d;
    logic [1:0]           dib_cnt_q, dib_cnt_d;
    logic [7:0]           byte_sr_q, byte_sr_d;
    logic [4:0]           hdr_idx_q, hdr_idx_d;
    logic [39:0]          field_q, field_d;
    logic [31:0]          crc_q, crc_d;
    logic [15:0]          pay_rem_q, pay_rem_d;
    logic [15:0]          slot_q, slot_d;
    logic [DATA_SIZE-1:0] word_q, word_d;
    logic                 axiov_q, axiov_d;
    logic [DATA_SIZE-1:0] axiod_q, axiod_d;
    logic [47:0]          src_mac_q, src_mac_d;
    logic [31:0]          src_ip_q, src_ip_d;
    logic [15:0]          udp_src_q, udp_src_d;
    logic [15:0]          pay_len_q, pay_len_d;
    logic                 done_q, done_d;
    logic                 good_q, good_d;

    logic [1:0]  rxd;
    logic [7:0]  rx_byte;
    logic [47:0] field_nxt;
    logic        in_body, in_frame, byte_done;

    assign rxd = eth_rxd[1:0];

    // Reflected CRC-32, data bits consumed LSB first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        dib_cnt_d = dib_cnt_q;
        byte_sr_d = byte_sr_q;
        hdr_idx_d = hdr_idx_q;
        field_d   = field_q;
        crc_d     = crc_q;
        pay_rem_d = pay_rem_q;
        slot_d    = slot_q;
        word_d    = word_q;
        axiov_d   = 1'b0;
        axiod_d   = axiod_q;
        src_mac_d = src_mac_q;
        src_ip_d  = src_ip_q;
        udp_src_d = udp_src_q;
        pay_len_d = pay_len_q;
        done_d    = 1'b0;
        good_d    = 1'b0;

        rx_byte   = {rxd, byte_sr_q[7:2]};
        field_nxt = {field_q, rx_byte};
        in_body   = state_q inside {StEthHdr, StIpHdr, StUdpHdr, StPayload, StTrailer};
        in_frame  = in_body || (state_q inside {StPreamble, StDrop});
        byte_done = eth_crsdv && in_body && (dib_cnt_q == 2'd3);

        if (in_body && eth_crsdv) begin
            crc_d     = crc_dibit(crc_q, rxd);
            dib_cnt_d = dib_cnt_q + 2'd1;
            byte_sr_d = rx_byte;
        end
        if (byte_done) begin
            field_d   = field_nxt[39:0];
            hdr_idx_d = hdr_idx_q + 5'd1;
        end

        case (state_q)
            StWaitIdle: if (!eth_crsdv) state_d = StIdle;
            StIdle: begin
                if (eth_crsdv && rxd == 2'b01) begin
                    state_d   = StPreamble;
                    pre_cnt_d = 3'd1;
                end
            end
            StPreamble: begin
                if (eth_crsdv) begin
                    if (rxd == 2'b01) begin
                        if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
                    end else if (rxd == 2'b11 && pre_cnt_q == 3'd7) begin
                        state_d   = StEthHdr;
                        crc_d     = '1;
                        dib_cnt_d = '0;
                        hdr_idx_d = '0;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StEthHdr: begin
                if (byte_done) begin
                    if (hdr_idx_q == 5'd5 && field_nxt != mac && field_nxt != '1) state_d = StDrop;
                    if (hdr_idx_q == 5'd11) src_mac_d = field_nxt;
                    if (hdr_idx_q == 5'd13) begin
                        hdr_idx_d = '0;
                        state_d   = (field_nxt[15:0] == 16'h0800) ? StIpHdr : StDrop;
                    end
                end
            end
            StIpHdr: begin
                if (byte_done) begin
                    if ((hdr_idx_q == 5'd0 && rx_byte != 8'h45) ||
                        (hdr_idx_q == 5'd9 && rx_byte != 8'h11)) state_d = StDrop;
                    if (hdr_idx_q == 5'd15) src_ip_d = field_nxt[31:0];
                    if (hdr_idx_q == 5'd19) begin
                        hdr_idx_d = '0;
                        state_d   = StUdpHdr;
                    end
                end
            end
            StUdpHdr: begin
                if (byte_done) begin
                    if (hdr_idx_q == 5'd1) udp_src_d = field_nxt[15:0];
                    if (hdr_idx_q == 5'd3 && field_nxt[15:0] != udp_dst_port_in) state_d = StDrop;
                    if (hdr_idx_q == 5'd5) begin
                        if (field_nxt[15:0] < 16'd8) state_d = StDrop;
                        else pay_len_d = field_nxt[15:0] - 16'd8;
                    end
                    if (hdr_idx_q == 5'd7) begin
                        pay_rem_d = pay_len_q;
                        slot_d    = '0;
                        word_d    = '0;
                        state_d   = (pay_len_q == 16'd0) ? StTrailer : StPayload;
                    end
                end
            end
            StPayload: begin
                if (byte_done) begin
                    for (int unsigned i = 0; i < Bytes; i++) begin
                        if (slot_q == 16'(i)) word_d[DATA_SIZE-1-8*i -: 8] = rx_byte;
                    end
                    pay_rem_d = pay_rem_q - 16'd1;
                    slot_d    = slot_q + 16'd1;
                    // Full word, or last payload byte: flush with unused low bytes left at zero.
                    if (slot_q == 16'(Bytes - 1) || pay_rem_q == 16'd1) begin
                        axiov_d = 1'b1;
                        axiod_d = word_d;
                        word_d  = '0;
                        slot_d  = '0;
                    end
                    if (pay_rem_q == 16'd1) state_d = StTrailer;
                end
            end
            default: ;
        endcase

        if (in_frame && !eth_crsdv) begin
            done_d  = 1'b1;
            good_d  = (state_q == StTrailer) && (dib_cnt_q == 2'd0) && (crc_q == CrcResidue);
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StWaitIdle;
            pre_cnt_q <= '0;
            dib_cnt_q <= '0;
            byte_sr_q <= '0;
            hdr_idx_q <= '0;
            field_q   <= '0;
            crc_q     <= '1;
            pay_rem_q <= '0;
            slot_q    <= '0;
            word_q    <= '0;
            axiov_q   <= 1'b0;
            axiod_q   <= '0;
            src_mac_q <= '0;
            src_ip_q  <= '0;
            udp_src_q <= '0;
            pay_len_q <= '0;
            done_q    <= 1'b0;
            good_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            dib_cnt_q <= dib_cnt_d;
            byte_sr_q <= byte_sr_d;
            hdr_idx_q <= hdr_idx_d;
            field_q   <= field_d;
            crc_q     <= crc_d;
            pay_rem_q <= pay_rem_d;
            slot_q    <= slot_d;
            word_q    <= word_d;
            axiov_q   <= axiov_d;
            axiod_q   <= axiod_d;
            src_mac_q <= src_mac_d;
            src_ip_q  <= src_ip_d;
            udp_src_q <= udp_src_d;
            pay_len_q <= pay_len_d;
            done_q    <= done_d;
            good_q    <= good_d;
        end
    end

    assign axiov            = axiov_q;
    assign axiod            = axiod_q;
    assign src_mac_out      = src_mac_q;
    assign src_ip_out       = src_ip_q;
    assign udp_src_port_out = udp_src_q;
    assign payload_length   = pay_len_q;
    assign frame_done       = done_q;
    assign frame_good       = good_q;
endmodule

// File: tb/tb_network_stack_rx.sv
// Bench for network_stack_rx: builds frames byte-wise with a software FCS, drives them as RMII
// dibits and compares payload words, header captures and verdicts against a frame-level model.
module tb_network_stack_rx;
    localparam int DS  = 16;
    localparam int B   = DS / 8;
    localparam int HDR = 42;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          crsdv = 1'b0;
    logic [1:0]    rxd   = 2'b00;
    logic [47:0]   mac   = 48'h02_12_34_56_78_9A;
    logic [15:0]   port  = 16'd42069;
    logic          axiov;
    logic [DS-1:0] axiod;
    logic [47:0]   src_mac_out;
    logic [31:0]   src_ip_out;
    logic [15:0]   udp_src_port_out;
    logic [15:0]   payload_length;
    logic          frame_done;
    logic          frame_good;

    always #5 clk = ~clk;

    network_stack_rx #(.N(2), .DATA_SIZE(DS)) dut (
        .clk              (clk),
        .rst              (rst),
        .eth_crsdv        (crsdv),
        .eth_rxd          (rxd),
        .mac              (mac),
        .udp_dst_port_in  (port),
        .axiov            (axiov),
        .axiod            (axiod),
        .src_mac_out      (src_mac_out),
        .src_ip_out       (src_ip_out),
        .udp_src_port_out (udp_src_port_out),
        .payload_length   (payload_length),
        .frame_done       (frame_done),
        .frame_good       (frame_good)
    );

    int            vec_cnt = 0;
    int            err_cnt = 0;
    logic [DS-1:0] got_w[$];
    logic [DS-1:0] exp_w[$];
    int            done_cnt = 0;
    logic          last_good = 1'b0;
    logic [7:0]    tx[$];
    logic [7:0]    pl[$];
    logic [47:0]   f_src_mac;
    logic [31:0]   f_src_ip;
    logic [15:0]   f_sport;

    always @(negedge clk) begin
        if (axiov === 1'b1) got_w.push_back(axiod);
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_good = frame_good;
        end
    end

    task automatic clear_mon();
        got_w.delete();
        done_cnt  = 0;
        last_good = 1'b0;
    endtask

    task automatic ref_fields(input int n);
        logic [7:0] r [0:13];
        r = '{8'hAB, 8'hCD, 8'h69, 8'h69, 8'hFF, 8'hFF, 8'h04, 8'h20,
              8'hAB, 8'hCD, 8'h69, 8'h69, 8'hFF, 8'hFF};
        f_src_mac = 48'h42_04_20_42_04_20;
        f_src_ip  = 32'h12_12_6B_0D;
        f_sport   = 16'd42069;
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(r[i]);
    endtask

    // Ethernet II / IPv4 / UDP frame from pl, padded to 60 bytes, FCS appended LSB byte first.
    task automatic build_frame(input logic [47:0] dst, input logic [7:0] proto,
                               input logic [15:0] dport);
        int          ulen;
        int          tot;
        logic [31:0] c;
        ulen = pl.size() + 8;
        tot  = ulen + 20;
        tx.delete();
        for (int i = 0; i < 6; i++) tx.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) tx.push_back(f_src_mac[47-8*i -: 8]);
        tx.push_back(8'h08); tx.push_back(8'h00);
        tx.push_back(8'h45); tx.push_back(8'h00); tx.push_back(tot[15:8]); tx.push_back(tot[7:0]);
        repeat (4) tx.push_back(8'h00);
        tx.push_back(8'h40); tx.push_back(proto); tx.push_back(8'h00); tx.push_back(8'h00);
        for (int i = 0; i < 4; i++) tx.push_back(f_src_ip[31-8*i -: 8]);
        repeat (4) tx.push_back(8'hFF);
        tx.push_back(f_sport[15:8]); tx.push_back(f_sport[7:0]);
        tx.push_back(dport[15:8]); tx.push_back(dport[7:0]);
        tx.push_back(ulen[15:8]); tx.push_back(ulen[7:0]);
        tx.push_back(8'h00); tx.push_back(8'h00);
        foreach (pl[i]) tx.push_back(pl[i]);
        while (tx.size() < 60) tx.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (tx[i]) begin
            c = c ^ {24'h0, tx[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) tx.push_back(c[8*i +: 8]);
    endtask

    // Words whose last payload byte lies inside the first rx_bytes frame bytes.
    task automatic model_words(input int plen, input int rx_bytes);
        int            last;
        logic [DS-1:0] v;
        exp_w.delete();
        for (int w = 0; w * B < plen; w++) begin
            last = ((w + 1) * B < plen) ? (w + 1) * B - 1 : plen - 1;
            v    = '0;
            if (HDR + last < rx_bytes) begin
                for (int b = 0; b < B; b++)
                    if (w * B + b < plen) v[DS-1-8*b -: 8] = tx[HDR + w * B + b];
                exp_w.push_back(v);
            end
        end
    endtask

    task automatic send_frame(input int cut, input int rst_at, input bit pre_rst);
        int         cnt  = 0;
        bit         stop = 1'b0;
        logic [7:0] b;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            crsdv = 1'b1;
            rst   = pre_rst && (i < 4);
            rxd   = (i == 31) ? 2'b11 : 2'b01;
        end
        foreach (tx[i]) begin
            b = tx[i];
            for (int d = 0; d < 4; d++) begin
                if (cut >= 0 && cnt == cut) stop = 1'b1;
                if (!stop) begin
                    @(negedge clk);
                    rst = (cnt == rst_at);
                    rxd = b[2*d +: 2];
                    cnt++;
                end
            end
        end
        @(negedge clk);
        crsdv = 1'b0;
        rst   = 1'b0;
        rxd   = 2'b00;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        crsdv = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({axiov, axiod, src_mac_out, src_ip_out, udp_src_port_out, payload_length,
             frame_done, frame_good} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %h expected 0", {axiov, axiod, src_mac_out,
                     src_ip_out, udp_src_port_out, payload_length, frame_done, frame_good});
        end
        // Reset released while carrier is already up: the whole frame must be ignored.
        ref_fields(14);
        build_frame('1, 8'h11, 16'd42069);
        clear_mon();
        send_frame(-1, -1, 1'b1);
        vec_cnt++;
        if (got_w.size() != 0 || done_cnt != 0 || src_ip_out !== 32'h0) begin
            err_cnt++;
            $display("FAIL wait_idle: got words=%0d done=%0d ip=%h expected 0 0 0",
                     got_w.size(), done_cnt, src_ip_out);
        end
    endtask

    task automatic test_reference();
        ref_fields(14);
        build_frame('1, 8'h11, 16'd42069);
        clear_mon();
        send_frame(-1, -1, 1'b0);
        model_words(14, tx.size());
        vec_cnt++;
        if (got_w.size() != exp_w.size()) begin
            err_cnt++;
            $display("FAIL ref_count: got %0d expected %0d", got_w.size(), exp_w.size());
        end else foreach (exp_w[i]) begin
            vec_cnt++;
            if (got_w[i] !== exp_w[i]) begin
                err_cnt++;
                $display("FAIL ref_word%0d: got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        vec_cnt++;
        if (done_cnt != 1 || last_good !== 1'b1) begin
            err_cnt++;
            $display("FAIL ref_verdict: got done=%0d good=%b expected 1 1", done_cnt, last_good);
        end
        vec_cnt++;
        if (payload_length !== 16'd14 || src_ip_out !== 32'h12126B0D ||
            src_mac_out !== 48'h420420420420 || udp_src_port_out !== 16'd42069) begin
            err_cnt++;
            $display("FAIL ref_headers: got len=%0d ip=%h mac=%h sport=%0d expected 14 12126b0d 420420420420 42069",
                     payload_length, src_ip_out, src_mac_out, udp_src_port_out);
        end
    endtask

    task automatic test_bitflip();
        ref_fields(14);
        build_frame('1, 8'h11, 16'd42069);
        tx[HDR + 5] = tx[HDR + 5] ^ 8'h08;
        clear_mon();
        send_frame(-1, -1, 1'b0);
        model_words(14, tx.size());
        vec_cnt++;
        if (got_w.size() != exp_w.size()) begin
            err_cnt++;
            $display("FAIL flip_count: got %0d expected %0d", got_w.size(), exp_w.size());
        end else foreach (exp_w[i]) begin
            vec_cnt++;
            if (got_w[i] !== exp_w[i]) begin
                err_cnt++;
                $display("FAIL flip_word%0d: got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        vec_cnt++;
        if (done_cnt != 1 || last_good !== 1'b0) begin
            err_cnt++;
            $display("FAIL flip_verdict: got done=%0d good=%b expected 1 0", done_cnt, last_good);
        end
    endtask

    task automatic test_filter();
        logic [47:0] dst [0:3];
        logic [7:0]  proto [0:3];
        logic [15:0] dport [0:3];
        dst   = '{48'h02_00_00_00_00_01, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        proto = '{8'h11, 8'h11, 8'h11, 8'h06};
        dport = '{16'd42069, 16'd42069, 16'd1234, 16'd42069};
        for (int t = 0; t < 4; t++) begin
            ref_fields(14);
            build_frame(dst[t], proto[t], dport[t]);
            clear_mon();
            send_frame(-1, -1, 1'b0);
            model_words(14, (t == 1) ? tx.size() : 0);
            vec_cnt++;
            if (got_w.size() != exp_w.size() || done_cnt != 1 || last_good !== (t == 1)) begin
                err_cnt++;
                $display("FAIL filter%0d: got words=%0d done=%0d good=%b expected %0d 1 %b",
                         t, got_w.size(), done_cnt, last_good, exp_w.size(), t == 1);
            end
        end
    endtask

    task automatic test_partial();
        ref_fields(13);
        build_frame('1, 8'h11, 16'd42069);
        clear_mon();
        send_frame(-1, -1, 1'b0);
        model_words(13, tx.size());
        vec_cnt++;
        if (got_w.size() != exp_w.size()) begin
            err_cnt++;
            $display("FAIL odd_count: got %0d expected %0d", got_w.size(), exp_w.size());
        end else foreach (exp_w[i]) begin
            vec_cnt++;
            if (got_w[i] !== exp_w[i]) begin
                err_cnt++;
                $display("FAIL odd_word%0d: got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
        vec_cnt++;
        if (done_cnt != 1 || last_good !== 1'b1 || payload_length !== 16'd13) begin
            err_cnt++;
            $display("FAIL odd_verdict: got done=%0d good=%b len=%0d expected 1 1 13",
                     done_cnt, last_good, payload_length);
        end
        ref_fields(14);
        build_frame('1, 8'h11, 16'd42069);
        clear_mon();
        send_frame(4 * (HDR + 5) + 2, -1, 1'b0);
        model_words(14, HDR + 5);
        vec_cnt++;
        if (got_w.size() != exp_w.size() || done_cnt != 1 || last_good !== 1'b0) begin
            err_cnt++;
            $display("FAIL trunc: got words=%0d done=%0d good=%b expected %0d 1 0",
                     got_w.size(), done_cnt, last_good, exp_w.size());
        end else foreach (exp_w[i]) begin
            vec_cnt++;
            if (got_w[i] !== exp_w[i]) begin
                err_cnt++;
                $display("FAIL trunc_word%0d: got %h expected %h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        ref_fields(14);
        build_frame('1, 8'h11, 16'd42069);
        clear_mon();
        send_frame(-1, 4 * (HDR + 6), 1'b0);
        model_words(14, HDR + 6);
        vec_cnt++;
        if (got_w.size() != exp_w.size() || done_cnt != 0 || src_ip_out !== 32'h0) begin
            err_cnt++;
            $display("FAIL mid_reset: got words=%0d done=%0d ip=%h expected %0d 0 0",
                     got_w.size(), done_cnt, src_ip_out, exp_w.size());
        end
        clear_mon();
        send_frame(-1, -1, 1'b0);
        model_words(14, tx.size());
        vec_cnt++;
        if (got_w.size() != exp_w.size() || done_cnt != 1 || last_good !== 1'b1) begin
            err_cnt++;
            $display("FAIL after_reset: got words=%0d done=%0d good=%b expected %0d 1 1",
                     got_w.size(), done_cnt, last_good, exp_w.size());
        end
    endtask

    task automatic test_random();
        int          plen;
        int          sel;
        bit          acc;
        logic [47:0] dst;
        for (int t = 0; t < 8; t++) begin
            f_src_mac = {16'($urandom), 32'($urandom)};
            f_src_ip  = 32'($urandom);
            f_sport   = 16'($urandom);
            plen      = $urandom_range(0, 24);
            sel       = $urandom_range(0, 2);
            dst       = (sel == 0) ? mac : (sel == 1) ? 48'hFFFF_FFFF_FFFF
                                                    : {16'h0A00, 32'($urandom)};
            acc       = (sel != 2);
            pl.delete();
            for (int i = 0; i < plen; i++) pl.push_back(8'($urandom));
            build_frame(dst, 8'h11, 16'd42069);
            clear_mon();
            send_frame(-1, -1, 1'b0);
            model_words(plen, acc ? tx.size() : 0);
            vec_cnt++;
            if (got_w.size() != exp_w.size() || done_cnt != 1 || last_good !== acc) begin
                err_cnt++;
                $display("FAIL rand%0d: got words=%0d done=%0d good=%b expected %0d 1 %b",
                         t, got_w.size(), done_cnt, last_good, exp_w.size(), acc);
            end else foreach (exp_w[i]) begin
                vec_cnt++;
                if (got_w[i] !== exp_w[i]) begin
                    err_cnt++;
                    $display("FAIL rand%0d_word%0d: got %h expected %h", t, i, got_w[i], exp_w[i]);
                end
            end
            if (acc) begin
                vec_cnt++;
                if (payload_length !== 16'(plen) || src_ip_out !== f_src_ip ||
                    src_mac_out !== f_src_mac || udp_src_port_out !== f_sport) begin
                    err_cnt++;
                    $display("FAIL rand%0d_hdr: got %0d %h %h %h expected %0d %h %h %h", t,
                             payload_length, src_ip_out, src_mac_out, udp_src_port_out,
                             plen, f_src_ip, f_src_mac, f_sport);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reference();
        test_bitflip();
        test_filter();
        test_partial();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
